// File: rtl/axi_llc_cfg_slv.sv
// AXI4-Lite configuration responder for the LLC: SPM way mask, flush handshake,
// live flushed status and captured BIST result, in a 16-byte register window.
module axi_llc_cfg_slv #(
    parameter int unsigned          AddrWidth        = 32,
    parameter int unsigned          SetAssociativity = 8,
    parameter logic [AddrWidth-1:0] BaseAddr         = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [AddrWidth-1:0]        aw_addr_i,
    input  logic                        aw_valid_i,
    output logic                        aw_ready_o,
    input  logic [31:0]                 w_data_i,
    input  logic [3:0]                  w_strb_i,
    input  logic                        w_valid_i,
    output logic                        w_ready_o,
    output logic [1:0]                  b_resp_o,
    output logic                        b_valid_o,
    input  logic                        b_ready_i,
    input  logic [AddrWidth-1:0]        ar_addr_i,
    input  logic                        ar_valid_i,
    output logic                        ar_ready_o,
    output logic [31:0]                 r_data_o,
    output logic [1:0]                  r_resp_o,
    output logic                        r_valid_o,
    input  logic                        r_ready_i,
    output logic [SetAssociativity-1:0] spm_cfg_o,
    output logic                        flush_valid_o,
    input  logic                        flush_ready_i,
    output logic [SetAssociativity-1:0] flush_ways_o,
    input  logic                        flush_done_i,
    input  logic [SetAssociativity-1:0] flushed_i,
    input  logic [SetAssociativity-1:0] bist_res_i,
    input  logic                        bist_valid_i
);

    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;
    // Bits at or above SetAssociativity are never stored, so they read back 0.
    localparam logic [31:0] WayMask    = 32'((64'd1 << SetAssociativity) - 64'd1);

    typedef enum logic       {W_IDLE, W_RESP}         w_state_e;
    typedef enum logic       {R_IDLE, R_RESP}         r_state_e;
    typedef enum logic [1:0] {F_IDLE, F_REQ, F_BUSY}  f_state_e;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } rd_rsp_t;

    w_state_e w_state, w_state_nxt;
    r_state_e r_state, r_state_nxt;
    f_state_e f_state, f_state_nxt;

    logic [31:0] spm_cfg_q, flush_q, bist_q;
    logic [1:0]  b_resp_q;
    rd_rsp_t     r_rsp_q, rd_rsp;

    // ---------------------------------------------------------------- write path
    logic        wr_hs, wr_in_win, wr_err, wr_ok;
    logic [1:0]  wr_idx;
    logic [31:0] strb_mask, wr_old, wr_merged;

    for (genvar i = 0; i < 4; i++) begin : g_strb
        assign strb_mask[8*i +: 8] = {8{w_strb_i[i]}};
    end

    assign wr_hs     = aw_ready_o & aw_valid_i;
    assign wr_in_win = (aw_addr_i[AddrWidth-1:4] == BaseAddr[AddrWidth-1:4]);
    assign wr_idx    = aw_addr_i[3:2];
    // Config writes are refused while a flush is outstanding so the way set stays coherent.
    assign wr_err    = !wr_in_win || wr_idx[1] || (f_state != F_IDLE);
    assign wr_ok     = wr_hs && !wr_err;
    assign wr_old    = wr_idx[0] ? flush_q : spm_cfg_q;
    assign wr_merged = ((wr_old & ~strb_mask) | (w_data_i & strb_mask)) & WayMask;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) w_state <= W_IDLE;
        else       w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (wr_hs)     w_state_nxt = W_RESP;
            W_RESP:  if (b_ready_i) w_state_nxt = W_IDLE;
            default:                w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        aw_ready_o = (w_state == W_IDLE) && aw_valid_i && w_valid_i && !rst_i;
        w_ready_o  = aw_ready_o;
        b_valid_o  = (w_state == W_RESP);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      b_resp_q <= RespOkay;
        else if (wr_hs) b_resp_q <= wr_err ? RespSlvErr : RespOkay;
    end

    assign b_resp_o = b_resp_q;

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spm_cfg_q <= '0;
            flush_q   <= '0;
            bist_q    <= '0;
        end else begin
            if (wr_ok && !wr_idx[0]) spm_cfg_q <= wr_merged;
            if (wr_ok && wr_idx[0])
                flush_q <= wr_merged;
            else if (f_state == F_BUSY && flush_done_i)
                flush_q <= '0;
            if (bist_valid_i) bist_q <= 32'(bist_res_i);
        end
    end

    assign spm_cfg_o = spm_cfg_q[SetAssociativity-1:0];

    // ---------------------------------------------------------------- flush FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) f_state <= F_IDLE;
        else       f_state <= f_state_nxt;
    end

    always_comb begin
        f_state_nxt = f_state;
        case (f_state)
            F_IDLE:  if (wr_ok && wr_idx == 2'd1 && wr_merged != '0) f_state_nxt = F_REQ;
            F_REQ:   if (flush_ready_i)                               f_state_nxt = F_BUSY;
            F_BUSY:  if (flush_done_i)                                f_state_nxt = F_IDLE;
            default:                                                  f_state_nxt = F_IDLE;
        endcase
    end

    always_comb begin
        flush_valid_o = (f_state == F_REQ);
        flush_ways_o  = flush_valid_o ? flush_q[SetAssociativity-1:0] : '0;
    end

    // ---------------------------------------------------------------- read path
    logic       rd_hs, rd_in_win;
    logic [1:0] rd_idx;
    logic       unused_addr_lsbs;

    assign unused_addr_lsbs = ^{aw_addr_i[1:0], ar_addr_i[1:0]};
    assign rd_hs     = ar_ready_o & ar_valid_i;
    assign rd_in_win = (ar_addr_i[AddrWidth-1:4] == BaseAddr[AddrWidth-1:4]);
    assign rd_idx    = ar_addr_i[3:2];

    always_comb begin
        rd_rsp = '{resp: RespSlvErr, data: 32'h0};
        if (rd_in_win) begin
            rd_rsp.resp = RespOkay;
            case (rd_idx)
                2'd0:    rd_rsp.data = spm_cfg_q;
                2'd1:    rd_rsp.data = flush_q;
                2'd2:    rd_rsp.data = 32'(flushed_i);
                default: rd_rsp.data = bist_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= R_IDLE;
        else       r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (rd_hs)     r_state_nxt = R_RESP;
            R_RESP:  if (r_ready_i) r_state_nxt = R_IDLE;
            default:                r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        ar_ready_o = (r_state == R_IDLE) && !rst_i;
        r_valid_o  = (r_state == R_RESP);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      r_rsp_q <= '0;
        else if (rd_hs) r_rsp_q <= rd_rsp;
    end

    assign r_data_o = r_rsp_q.data;
    assign r_resp_o = r_rsp_q.resp;

endmodule

// File: doc/axi_llc_cfg_slv.md
Name: axi_llc_cfg_slv

Overview:
- AXI4-Lite responder for the LLC configuration port. Holds the four 32-bit config registers: spm_cfg, flush, flushed and bist_out.
- Drives the SPM way mask into the LLC datapath.
- Runs the flush request/acknowledge handshake towards the flush unit.
- Sits between the SoC AXI-Lite interconnect and the LLC control logic, in the same clock domain as the cache.

Parameters:
- AddrWidth, 32, width of the AXI-Lite address (LitePortAddrWidth); data width is fixed at 32.
- SetAssociativity, 8, number of ways; 1..32; register bits at or above this index read 0 and ignore writes.
- BaseAddr, 32'h0, base of the 16-byte register window; must be 16-byte aligned.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- aw_addr_i  in  AddrWidth  write address
- aw_valid_i  in  1 / aw_ready_o  out  1  AW handshake
- w_data_i  in  32 / w_strb_i  in  4  write data and byte strobes
- w_valid_i  in  1 / w_ready_o  out  1  W handshake
- b_resp_o  out  2 / b_valid_o  out  1 / b_ready_i  in  1  write response
- ar_addr_i  in  AddrWidth / ar_valid_i  in  1 / ar_ready_o  out  1  read address
- r_data_o  out  32 / r_resp_o  out  2 / r_valid_o  out  1 / r_ready_i  in  1  read response
- spm_cfg_o  out  SetAssociativity  ways configured as scratchpad
- flush_valid_o  out  1 / flush_ready_i  in  1  flush request handshake
- flush_ways_o  out  SetAssociativity  ways to flush
- flush_done_i  in  1  one-cycle pulse: requested flush complete
- flushed_i  in  SetAssociativity  ways currently flushed (live status)
- bist_res_i  in  SetAssociativity / bist_valid_i  in  1  BIST result and capture strobe

Behaviour:
- Register map (offset from BaseAddr):
  - 0x0 spm_cfg: RW
  - 0x4 flush: RW
  - 0x8 flushed: RO, returns flushed_i sampled at the AR handshake
  - 0xC bist_out: RO, captured whenever bist_valid_i=1
- Decode uses addr[3:2] once addr[AddrWidth-1:4] equals BaseAddr[AddrWidth-1:4]; addr[1:0] are ignored.
- Reset values: every register 0, all valid/ready outputs 0, b_resp_o/r_resp_o/r_data_o 0, flush FSM in F_IDLE.
- Reset asserted mid-transaction: everything returns to reset values; flush_valid_o drops immediately.
- Write FSM, W_IDLE -> W_RESP:
  - In W_IDLE, aw_ready_o = w_ready_o = aw_valid_i & w_valid_i, so AW and W are accepted in the same cycle, never one alone.
  - On acceptance the register is updated per byte lane from w_strb_i. The new value is visible on outputs the next cycle.
  - b_valid_o rises the cycle after acceptance and holds, with b_resp_o stable, until b_ready_i. The FSM then returns to W_IDLE. Minimum 2 cycles per write.
- Read FSM, R_IDLE -> R_RESP:
  - In R_IDLE, ar_ready_o = 1. r_data_o/r_resp_o are registered at the AR handshake.
  - r_valid_o holds until r_ready_i. Minimum 2 cycles per read.
- Read and write FSMs are independent. A read accepted in the same cycle as a write to the same register returns the old value.
- Response codes are OKAY (2'b00) or SLVERR (2'b10). SLVERR with no register update for:
  - an address outside the window;
  - a write to 0x8 or 0xC;
  - a write to 0x0 or 0x4 while the flush FSM is not F_IDLE.
- A read outside the window returns SLVERR with data 0.
- Flush FSM:
  - F_IDLE: an OKAY write to flush with a nonzero masked value -> F_REQ. Writing 0 stays in F_IDLE.
  - F_REQ: flush_valid_o=1, flush_ways_o = flush register, both stable until flush_ready_i; on handshake -> F_BUSY.
  - F_BUSY: wait for flush_done_i; then the flush register clears to 0 -> F_IDLE.
  - flush_done_i outside F_BUSY is ignored.
  - flush_ways_o = 0 whenever flush_valid_o = 0.
- spm_cfg_o = spm_cfg register, masked to SetAssociativity bits.

Test Plan:
- Reset, then read 0x0, 0x4, 0x8 (flushed_i=8'h0F), 0xC -> r_data 0, 0, 32'h0F, 0; all OKAY; each r_valid_o exactly 1 cycle after its AR handshake.
- Write 0x0 data 32'hFFFF_FF3C strb 4'b0001 -> OKAY; spm_cfg_o=8'h3C next cycle; readback 0x0 = 32'h3C.
- Write 0x4 data 32'h81; flush_ready_i held low 5 cycles -> flush_valid_o=1 and flush_ways_o=8'h81 stable throughout. Ready, then flush_done_i pulse -> reads of 0x4 return 32'h81 while busy and 0 after done.
- While flush is in F_BUSY, write 0x0 and write 0x4 -> both SLVERR; spm_cfg and flush unchanged.
- Write 0xC, write BaseAddr+0x10, read BaseAddr+0x20 -> SLVERR, SLVERR, SLVERR with data 0. bist_valid_i with bist_res_i=8'hA5 -> read 0xC = 32'hA5.
- aw_valid_i without w_valid_i for 3 cycles -> aw_ready_o=0 throughout. Then assert w_valid_i and hold b_ready_i low 4 cycles -> b_valid_o held and a concurrent read still completes. rst_i asserted in F_REQ -> flush_valid_o=0 the same cycle.
